alpha_sched: RTL and testbench

- Access sequencer for the alpha (LLR) layer memory of the SCAN polar decoder. It is the initiator side of that memory's read/write port.
- Given a descent request from layer_top down to layer_bot, it does the following for each layer step:
  - issues chunked reads of the current layer;
  - drives the PE op select;
  - issues the matching writes into the layer below, delayed by the read-register plus PE pipeline latency.
- Sits between the top-level SCAN controller and the alpha memory/PE array.

---
 rtl/alpha_sched_if.sv | 18 +
 rtl/alpha_sched.sv | 164 ++++++++++++++++
 tb/tb_alpha_sched.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alpha_sched_if.sv
// Alpha (LLR) layer memory read/write port plus PE op select.
// The sequencer drives it as master; the memory/PE array side is the slave.
interface alpha_sched_if;
    logic       r_en;
    logic [4:0] layer_r;
    logic [5:0] cntb;
    logic       w_en;
    logic [4:0] layer_w;
    logic [6:0] cnta;
    logic       pe_op;

    modport master (
        output r_en, layer_r, cntb, w_en, layer_w, cnta, pe_op
    );
    modport slave (
        input  r_en, layer_r, cntb, w_en, layer_w, cnta, pe_op
    );
endinterface

// File: rtl/alpha_sched.sv
// SCAN decoder alpha-memory access sequencer: chunked reads of one layer,
// PE op select, and latency-matched writes into the layer below.
module alpha_sched #(
    parameter int N      = 1024,
    parameter int LOG_N  = 10,
    parameter int P      = 16,
    parameter int LOG_P  = 4,
    parameter int PE_LAT = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [4:0]           layer_top,
    input  logic [4:0]           layer_bot,
    input  logic                 op_first,
    alpha_sched_if.master        mem,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam int DEPTH = PE_LAT + 1;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, FINISH} state_t;

    state_t     state, state_n;
    logic [4:0] cur, cur_n;
    logic [4:0] bot, bot_n;
    logic       cur_op, cur_op_n;
    logic [5:0] k, k_n;
    logic [5:0] last_k;
    logic       err_n;
    logic       err_q;
    logic       pe_op_q;
    logic       req_bad;
    logic       reading;
    logic       pipe_busy;
    int         sh;

    logic       vld_p   [DEPTH];
    logic [5:0] chunk_p [DEPTH];
    logic [4:0] layer_p [DEPTH];

    // Last chunk index of the current layer: 2^(cur-1-LOG_P) chunks, minimum one.
    always_comb begin
        sh     = int'(cur) - 1 - LOG_P;
        last_k = '0;
        if (sh > 0)
            last_k = 6'((1 << sh) - 1);
    end

    assign req_bad = (layer_top > 5'(LOG_N)) || (layer_top < 5'd2) ||
                     (layer_bot == 5'd0) || (layer_bot >= layer_top);

    // Writes still in flight that land after this cycle; the last stage is
    // the one on the bus now, so it does not hold off the next read.
    always_comb begin
        pipe_busy = 1'b0;
        for (int i = 0; i < PE_LAT; i++)
            pipe_busy = pipe_busy | vld_p[i];
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n  = state;
        cur_n    = cur;
        bot_n    = bot;
        cur_op_n = cur_op;
        k_n      = k;
        err_n    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (req_bad) begin
                        err_n = 1'b1;
                    end else begin
                        state_n  = READ;
                        cur_n    = layer_top;
                        bot_n    = layer_bot;
                        cur_op_n = op_first;
                        k_n      = '0;
                    end
                end
            end
            READ: begin
                if (k == last_k) begin
                    state_n = DRAIN;
                    k_n     = '0;
                end else begin
                    k_n = k + 6'd1;
                end
            end
            DRAIN: begin
                if (!pipe_busy) begin
                    if (cur - 5'd1 == bot) begin
                        state_n = FINISH;
                    end else begin
                        cur_n    = cur - 5'd1;
                        cur_op_n = 1'b0;
                        state_n  = READ;
                    end
                end
            end
            FINISH:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign reading = (state == READ);

    always_ff @(posedge clk) begin
        if (rst) begin
            cur     <= '0;
            bot     <= '0;
            cur_op  <= 1'b0;
            k       <= '0;
            err_q   <= 1'b0;
            pe_op_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++)
                vld_p[i] <= 1'b0;
        end else begin
            cur    <= cur_n;
            bot    <= bot_n;
            cur_op <= cur_op_n;
            k      <= k_n;
            err_q  <= err_n;
            if (reading)
                pe_op_q <= cur_op;
            vld_p[0] <= reading;
            for (int i = 1; i < DEPTH; i++)
                vld_p[i] <= vld_p[i-1];
        end
    end

    // Write pipeline payload: chunk and destination layer, qualified by vld_p.
    always_ff @(posedge clk) begin
        chunk_p[0] <= k;
        layer_p[0] <= cur - 5'd1;
        for (int i = 1; i < DEPTH; i++) begin
            chunk_p[i] <= chunk_p[i-1];
            layer_p[i] <= layer_p[i-1];
        end
    end

    always_comb begin
        mem.r_en    = reading;
        mem.layer_r = reading ? cur : 5'd0;
        mem.cntb    = reading ? k : 6'd0;
        mem.w_en    = vld_p[PE_LAT];
        mem.layer_w = vld_p[PE_LAT] ? layer_p[PE_LAT] : 5'd0;
        mem.cnta    = vld_p[PE_LAT] ? {1'b0, chunk_p[PE_LAT]} : 7'd0;
        mem.pe_op   = pe_op_q;
        busy        = (state == READ) || (state == DRAIN);
        done        = (state == FINISH);
        err         = err_q;
    end

endmodule

// File: tb/tb_alpha_sched.sv
// Directed bench for alpha_sched: cycle-exact output vectors per scenario.
module tb_alpha_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [4:0] layer_top = '0;
    logic [4:0] layer_bot = '0;
    logic       op_first = 1'b0;
    logic       busy, done, err;
    int         checks = 0;
    int         failures = 0;

    alpha_sched_if mem ();

    alpha_sched #(.N(1024), .LOG_N(10), .P(16), .LOG_P(4), .PE_LAT(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .layer_top (layer_top),
        .layer_bot (layer_bot),
        .op_first  (op_first),
        .mem       (mem.master),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // {busy, done, err, r_en, layer_r, cntb, w_en, layer_w, cnta, pe_op}
    logic [28:0] obs;
    assign obs = {busy, done, err, mem.r_en, mem.layer_r, mem.cntb,
                  mem.w_en, mem.layer_w, mem.cnta, mem.pe_op};

    function automatic logic [28:0] pk(input bit b, input bit d, input bit e,
                                       input bit re, input int lr, input int cb,
                                       input bit we, input int lw, input int ca,
                                       input bit po);
        return {b, d, e, re, 5'(lr), 6'(cb), we, 5'(lw), 7'(ca), po};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        start = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic launch(input int top, input int bot, input bit op);
        layer_top = 5'(top);
        layer_bot = 5'(bot);
        op_first  = op;
        start     = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        tick();
        tick();
        @(negedge clk);
        checks++;
        if (obs !== 29'd0) begin
            failures++;
            $display("FAIL reset_idle: got %h expected %h", obs, 29'd0);
        end
        tick();
        layer_top = 5'd10;
        layer_bot = 5'd9;
        start     = 1'b1;
        tick();
        @(negedge clk);
        checks++;
        if (obs !== 29'd0) begin
            failures++;
            $display("FAIL reset_holds_start: got %h expected %h", obs, 29'd0);
        end
        tick();
        start = 1'b0;
        rst   = 1'b0;
    endtask

    task automatic test_single_step();
        logic [28:0] e;
        do_reset();
        launch(10, 9, 1'b1);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            e = pk(c >= 1 && c <= 35, c == 36, 1'b0,
                   c <= 32, (c <= 32) ? 10 : 0, (c <= 32) ? c - 1 : 0,
                   c >= 4 && c <= 35, (c >= 4 && c <= 35) ? 9 : 0,
                   (c >= 4 && c <= 35) ? c - 4 : 0, c >= 2);
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL single_step cycle %0d: got %h expected %h", c, obs, e);
            end
            tick();
        end
    endtask

    task automatic test_two_steps();
        logic [28:0] e;
        bit r1, r2, w1, w2;
        do_reset();
        launch(10, 8, 1'b0);
        for (int c = 1; c <= 58; c++) begin
            @(negedge clk);
            r1 = (c >= 1 && c <= 32);
            r2 = (c >= 36 && c <= 51);
            w1 = (c >= 4 && c <= 35);
            w2 = (c >= 39 && c <= 54);
            e = pk(c >= 1 && c <= 54, c == 55, 1'b0,
                   r1 || r2, r1 ? 10 : (r2 ? 9 : 0), r1 ? c - 1 : (r2 ? c - 36 : 0),
                   w1 || w2, w1 ? 9 : (w2 ? 8 : 0), w1 ? c - 4 : (w2 ? c - 39 : 0),
                   1'b0);
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL two_steps cycle %0d: got %h expected %h", c, obs, e);
            end
            tick();
        end
    endtask

    task automatic test_small_layers();
        logic [28:0] e;
        bit re, we;
        do_reset();
        launch(5, 1, 1'b1);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            re = (c % 4 == 1) && c <= 13;
            we = (c % 4 == 0) && c >= 4 && c <= 16;
            e = pk(c >= 1 && c <= 16, c == 17, 1'b0,
                   re, re ? 5 - (c - 1) / 4 : 0, 0,
                   we, we ? 4 - (c - 4) / 4 : 0, 0,
                   c >= 2 && c <= 5);
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL small_layers cycle %0d: got %h expected %h", c, obs, e);
            end
            tick();
        end
    endtask

    task automatic test_invalid();
        int tops [3] = '{11, 6, 6};
        int bots [3] = '{9, 0, 6};
        logic [28:0] e;
        for (int v = 0; v < 3; v++) begin
            do_reset();
            launch(tops[v], bots[v], 1'b1);
            for (int c = 1; c <= 3; c++) begin
                @(negedge clk);
                e = pk(1'b0, 1'b0, c == 1, 1'b0, 0, 0, 1'b0, 0, 0, 1'b0);
                checks++;
                if (obs !== e) begin
                    failures++;
                    $display("FAIL invalid%0d cycle %0d: got %h expected %h", v, c, obs, e);
                end
                tick();
            end
        end
    endtask

    task automatic test_reset_mid_run();
        logic [28:0] e;
        bit live;
        do_reset();
        launch(10, 9, 1'b0);
        for (int c = 1; c <= 40; c++) begin
            rst = (c == 20);
            @(negedge clk);
            live = (c <= 20);
            e = pk(live, 1'b0, 1'b0,
                   live, live ? 10 : 0, live ? c - 1 : 0,
                   live && c >= 4, (live && c >= 4) ? 9 : 0, (live && c >= 4) ? c - 4 : 0,
                   1'b0);
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL reset_mid_run cycle %0d: got %h expected %h", c, obs, e);
            end
            tick();
        end
        rst = 1'b0;
    endtask

    // Runs straight after the aborted run, so it also shows a fresh start is accepted.
    task automatic test_start_while_busy();
        logic [28:0] e;
        launch(10, 9, 1'b1);
        for (int c = 1; c <= 40; c++) begin
            if (c == 10) begin
                layer_top = 5'd3;
                layer_bot = 5'd1;
                op_first  = 1'b0;
                start     = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            e = pk(c >= 1 && c <= 35, c == 36, 1'b0,
                   c <= 32, (c <= 32) ? 10 : 0, (c <= 32) ? c - 1 : 0,
                   c >= 4 && c <= 35, (c >= 4 && c <= 35) ? 9 : 0,
                   (c >= 4 && c <= 35) ? c - 4 : 0, c >= 2);
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL start_while_busy cycle %0d: got %h expected %h", c, obs, e);
            end
            tick();
        end
    endtask

    initial begin
        tick();
        test_reset();
        test_single_step();
        test_two_steps();
        test_small_layers();
        test_invalid();
        test_reset_mid_run();
        test_start_while_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
